in_spike_enc: RTL and testbench

- Input-side sequencer and rate encoder. It drives the output neuron block and consumes that block's completion handshake.
- Holds one image of M 8-bit pixels and converts them to deterministic rate-coded spike vectors using per-pixel phase accumulators.
- Runs T_STEPS time units per image. Each time unit: issue start_op_nub, wait for valid_op_nub, tally output spikes, pulse TU_incre.
- Also exports per-pixel input spike counts (count bus) for the weight-change path.

---
 rtl/in_spike_enc_pkg.sv | 34 +++
 rtl/in_spike_enc_if.sv | 27 ++
 rtl/in_spike_enc_pix_rate_cell.sv | 47 ++++
 rtl/in_spike_enc.sv | 160 ++++++++++++++++
 tb/tb_in_spike_enc.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/in_spike_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | in_spike_enc_pkg                                                     |
// | Shared state encoding, saturating counter helper, accumulator preset |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package in_spike_enc_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ENC   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ADV   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        INIT  = S_INIT,
        ENC   = S_ENC,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        ADV   = S_ADV,
        DONE  = S_DONE
    } state_t;

    localparam logic [7:0] ACC_INIT_DEF = 8'd0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_spike_enc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | in_spike_enc_if                                                      |
// | Handshake between the input encoder and the output neuron block      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface in_spike_enc_if #(
    parameter int M = 784,
    parameter int N = 8
);
    logic         start_op_nub;
    logic         valid_op_nub;
    logic [N-1:0] spike_op_nub;
    logic [M-1:0] spike_ip_nub;
    logic         TU_incre;

    modport master (
        output start_op_nub, spike_ip_nub, TU_incre,
        input  valid_op_nub, spike_op_nub
    );

    modport slave (
        input  start_op_nub, spike_ip_nub, TU_incre,
        output valid_op_nub, spike_op_nub
    );
endinterface
`default_nettype wire

// File: rtl/in_spike_enc_pix_rate_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | in_spike_enc_pix_rate_cell                                           |
// | Per-pixel phase accumulator: spike on carry-out, saturating count    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module in_spike_enc_pix_rate_cell
    import in_spike_enc_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       init,
    input  wire logic       step,
    input  wire logic       clr,
    input  wire logic [7:0] pix,
    input  wire logic [7:0] acc_init,
    output logic            spike,
    output logic [7:0]      count
);

    logic [7:0] r_acc;
    logic [8:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, pix};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 8'd0;
            spike <= 1'b0;
            count <= 8'd0;
        end else if (init) begin
            r_acc <= acc_init;
            spike <= 1'b0;
            count <= 8'd0;
        end else if (step) begin
            r_acc <= w_sum[7:0];
            spike <= w_sum[8];
            if (w_sum[8]) begin
                count <= sat_inc8(count);
            end
        end else if (clr) begin
            spike <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/in_spike_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | in_spike_enc                                                         |
// | Image store, rate encoder and time-unit sequencer for the output     |
// | neuron block. Optional watchdog: IN_SPIKE_ENC_WDOG_EN                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module in_spike_enc
    import in_spike_enc_pkg::*;
#(
    parameter int         M        = 784,
    parameter int         N        = 8,
    parameter int         T_STEPS  = 64,
    parameter int         AW       = 10,
    parameter logic [7:0] ACC_INIT = ACC_INIT_DEF,
    parameter int         WDOG_CYC = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          pix_we,
    input  wire logic [AW-1:0] pix_addr,
    input  wire logic [7:0]    pix_din,
    input  wire logic          start_img,
    output logic               busy,
    output logic               start_core_img,
    in_spike_enc_if.master     nub,
    output logic [8*M-1:0]     count,
    output logic [8*N-1:0]     out_cnt,
    output logic [15:0]        tu_idx,
    output logic               img_done,
    output logic               err_timeout
);

    if (T_STEPS < 1 || WDOG_CYC < 1) begin : g_param_check
        $error("in_spike_enc: T_STEPS and WDOG_CYC must be >= 1");
    end

    state_t       r_state;
    logic         r_start_op;
    logic         r_tu_incre;
    logic [7:0]   mem [M];
    logic [M-1:0] w_spike;
    logic         w_pix_wr;

    // Pixel memory has no reset so a stored image survives an aborted run.
    assign w_pix_wr = pix_we && (r_state == IDLE) && (int'(pix_addr) < M);

    always_ff @(posedge clk) begin
        if (w_pix_wr) begin
            mem[pix_addr] <= pix_din;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_cell
        in_spike_enc_pix_rate_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .init     (r_state == INIT),
            .step     (r_state == ENC),
            .clr      (r_state == DONE),
            .pix      (mem[i]),
            .acc_init (ACC_INIT),
            .spike    (w_spike[i]),
            .count    (count[8*i +: 8])
        );
    end

    assign busy             = (r_state != IDLE);
    assign nub.spike_ip_nub = w_spike;
    assign nub.start_op_nub = r_start_op;
    assign nub.TU_incre     = r_tu_incre;

`ifdef IN_SPIKE_ENC_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic [WDW-1:0] r_wd;
`else
    assign err_timeout = 1'b0;
`endif

    // Pulse outputs are loaded on the transition so they coincide with their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            tu_idx         <= 16'd0;
            out_cnt        <= '0;
            start_core_img <= 1'b0;
            r_start_op     <= 1'b0;
            r_tu_incre     <= 1'b0;
            img_done       <= 1'b0;
`ifdef IN_SPIKE_ENC_WDOG_EN
            r_wd           <= '0;
            err_timeout    <= 1'b0;
`endif
        end else begin
            start_core_img <= 1'b0;
            r_start_op     <= 1'b0;
            r_tu_incre     <= 1'b0;
            img_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_img) begin
                        r_state        <= INIT;
                        start_core_img <= 1'b1;
                    end
                end
                INIT: begin
                    tu_idx  <= 16'd0;
                    out_cnt <= '0;
`ifdef IN_SPIKE_ENC_WDOG_EN
                    err_timeout <= 1'b0;
`endif
                    r_state <= ENC;
                end
                ENC: begin
                    r_start_op <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
`ifdef IN_SPIKE_ENC_WDOG_EN
                    r_wd <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (nub.valid_op_nub) begin
                        for (int j = 0; j < N; j++) begin
                            if (nub.spike_op_nub[j]) begin
                                out_cnt[8*j +: 8] <= sat_inc8(out_cnt[8*j +: 8]);
                            end
                        end
                        r_tu_incre <= 1'b1;
                        r_state    <= ADV;
                    end
`ifdef IN_SPIKE_ENC_WDOG_EN
                    else if (r_wd == WDW'(WDOG_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        r_tu_incre  <= 1'b1;
                        r_state     <= ADV;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                ADV: begin
                    if (tu_idx == 16'(T_STEPS - 1)) begin
                        img_done <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        tu_idx  <= tu_idx + 16'd1;
                        r_state <= ENC;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_in_spike_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_in_spike_enc                                                      |
// | Self-checking bench with an arithmetic rate-coding reference model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_in_spike_enc;

    localparam int         M     = 12;
    localparam int         N     = 8;
    localparam int         T     = 300;
    localparam int         AW    = 4;
    localparam int         WDOG  = 16;
    localparam int         LIMIT = 20000;
    localparam logic [7:0] A     = 8'd0;
`ifdef IN_SPIKE_ENC_WDOG_EN
    localparam int LONG_DLY = 10;
`else
    localparam int LONG_DLY = 50;
`endif

    logic           clk = 1'b0;
    logic           rst, pix_we, start_img;
    logic [AW-1:0]  pix_addr;
    logic [7:0]     pix_din;
    logic           busy, start_core_img, img_done, err_timeout;
    logic [8*M-1:0] count;
    logic [8*N-1:0] out_cnt;
    logic [15:0]    tu_idx;

    in_spike_enc_if #(.M(M), .N(N)) nub ();

    in_spike_enc #(
        .M(M), .N(N), .T_STEPS(T), .AW(AW), .ACC_INIT(A), .WDOG_CYC(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .pix_we(pix_we), .pix_addr(pix_addr), .pix_din(pix_din),
        .start_img(start_img), .busy(busy), .start_core_img(start_core_img), .nub(nub),
        .count(count), .out_cnt(out_cnt), .tu_idx(tu_idx), .img_done(img_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: stored pixels and output spikes the responder delivered.
    int           pix_m [M];
    int           tally [N];
    int           tu_m = 0;
    int           img_dones = 0;
    bit           stab = 1'b0;
    logic [M-1:0] cap = '0;
    int           exp_err = 0;

    bit           resp_en = 1'b0;
    bit           resp_spur = 1'b0;
    bit           pat_rand = 1'b0;
    int           dly_lo = 0;
    int           dly_hi = 0;
    int           long_left = 0;

    typedef struct packed {
        logic [7:0] pix;
        logic [7:0] exp_cnt;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Spike for pixel p at time unit t: did floor((A + p*k)/256) step between k=t and k=t+1?
    function automatic logic [M-1:0] exp_spikes(input int t);
        logic [M-1:0] v;
        for (int p = 0; p < M; p++) begin
            v[p] = ((int'(A) + pix_m[p] * (t + 1)) / 256) != ((int'(A) + pix_m[p] * t) / 256);
        end
        return v;
    endfunction

    function automatic int exp_count(input int p);
        int s;
        s = (int'(A) + pix_m[p] * T) / 256;
        return (s > 255) ? 255 : s;
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (start_core_img) tu_m = 0;
                if (nub.start_op_nub) begin
                    chk("spike_ip_nub", nub.spike_ip_nub, exp_spikes(tu_m));
                    cap  = nub.spike_ip_nub;
                    stab = 1'b1;
                end else if (nub.spike_ip_nub != cap) begin
                    stab = 1'b0;
                end
                if (nub.TU_incre) begin
                    chk("spike_stable", stab, 1);
                    chk("tu_idx", tu_idx, tu_m);
                    tu_m++;
                end
                if (img_done) img_dones++;
            end
        end
    end

    initial begin : responder
        int d;
        logic [N-1:0] pat;
        nub.valid_op_nub = 1'b0;
        nub.spike_op_nub = '0;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && nub.start_op_nub) begin
                if (long_left > 0) begin
                    d = LONG_DLY;
                    long_left--;
                end else begin
                    d = $urandom_range(dly_hi, dly_lo);
                end
                if (resp_spur) begin
                    nub.valid_op_nub = 1'b1;
                    nub.spike_op_nub = '1;
                end
                @(negedge clk);
                nub.valid_op_nub = 1'b0;
                nub.spike_op_nub = '0;
                repeat (d) @(negedge clk);
                pat = pat_rand ? N'($urandom) : 8'b0000_0101;
                nub.valid_op_nub = 1'b1;
                nub.spike_op_nub = pat;
                for (int j = 0; j < N; j++) tally[j] += int'(pat[j]);
                @(negedge clk);
                nub.valid_op_nub = 1'b0;
                nub.spike_op_nub = '0;
            end
        end
    end

    task automatic load_pix(input int addr, input logic [7:0] val);
        pix_we   = 1'b1;
        pix_addr = AW'(addr);
        pix_din  = val;
        @(negedge clk);
        pix_we = 1'b0;
        if (addr < M) pix_m[addr] = int'(val);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start_core_img"}, start_core_img, 0);
        chk({tag, "_spike_ip_nub"}, nub.spike_ip_nub, 0);
        chk({tag, "_start_op_nub"}, nub.start_op_nub, 0);
        chk({tag, "_TU_incre"}, nub.TU_incre, 0);
        chk({tag, "_count_zero"}, (count == '0), 1);
        chk({tag, "_out_cnt"}, out_cnt, 0);
        chk({tag, "_tu_idx"}, tu_idx, 0);
        chk({tag, "_img_done"}, img_done, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic start_image();
        for (int j = 0; j < N; j++) tally[j] = 0;
        start_img = 1'b1;
        @(negedge clk);
        start_img = 1'b0;
        chk("start_core_img_latency", start_core_img, 1);
        chk("busy_in_image", busy, 1);
        @(negedge clk);
        chk("init_tu_idx", tu_idx, 0);
        chk("init_count_cleared", (count == '0), 1);
        chk("init_out_cnt_cleared", out_cnt, 0);
    endtask

    task automatic wait_done();
        int n;
        int prev;
        prev = img_dones;
        n = 0;
        while (!img_done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("img_done_within_limit", img_done, 1);
        chk("tu_incre_pulses", tu_m, T);
        @(negedge clk);
        chk("img_done_once", img_dones, prev + 1);
        chk("idle_busy", busy, 0);
        chk("idle_spike_ip_nub", nub.spike_ip_nub, 0);
    endtask

    task automatic check_counts();
        int e;
        for (int p = 0; p < M; p++) chk("count", count[8*p +: 8], exp_count(p));
        for (int j = 0; j < N; j++) begin
            e = (tally[j] > 255) ? 255 : tally[j];
            chk("out_cnt", out_cnt[8*j +: 8], e);
        end
        chk("err_timeout", err_timeout, exp_err);
    endtask

    initial begin : main
        int  n;
        bit  any_done;

        tbl[0] = '{8'd128, 8'd150};
        tbl[1] = '{8'd255, 8'd255};
        tbl[2] = '{8'd0,   8'd0};
        tbl[3] = '{8'd1,   8'd1};
        tbl[4] = '{8'd64,  8'd75};
        tbl[5] = '{8'd200, 8'd234};
        tbl[6] = '{8'd86,  8'd100};
        tbl[7] = '{8'd2,   8'd2};

        rst = 1'b1; pix_we = 1'b0; pix_addr = '0; pix_din = '0; start_img = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Image 1: table pixels, immediate response with fixed spike pattern
        for (int p = 0; p < 8; p++) load_pix(p, tbl[p].pix);
        for (int p = 8; p < M; p++) load_pix(p, 8'($urandom));
        for (int a = M; a < (1 << AW); a++) load_pix(a, 8'hAA);
        resp_en = 1'b1; resp_spur = 1'b0; pat_rand = 1'b0; dly_lo = 0; dly_hi = 0;
        start_image();
        load_pix(99, 8'd0);
        pix_we = 1'b1; pix_addr = '0; pix_din = 8'd7;
        @(negedge clk);
        pix_we = 1'b0;
        wait_done();
        for (int p = 0; p < 8; p++) chk("table_count", count[8*p +: 8], tbl[p].exp_cnt);
        chk("out_cnt0_sat", out_cnt[7:0], 255);
        chk("out_cnt2_sat", out_cnt[23:16], 255);
        chk("out_cnt1_zero", out_cnt[15:8], 0);
        check_counts();

        // Image 2: random pixels, random delays, long waits and spurious valids in ISSUE
        for (int p = 2; p < M; p++) load_pix(p, 8'($urandom));
        resp_spur = 1'b1; pat_rand = 1'b1; dly_lo = 0; dly_hi = 3; long_left = 3;
        start_image();
        wait_done();
        check_counts();

        // Image 3: reset during WAIT of the third time unit
        resp_spur = 1'b0; dly_lo = 5; dly_hi = 5;
        start_image();
        n = 0;
        while (!(nub.start_op_nub && tu_m == 2) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_tu2", (n < LIMIT), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("abort");
        any_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_done |= img_done;
        end
        chk("abort_no_img_done", any_done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Image 4: restart with retained pixel memory
        dly_lo = 0; dly_hi = 2;
        start_image();
        wait_done();
        check_counts();

`ifdef IN_SPIKE_ENC_WDOG_EN
        // Image 5: no response at all, every time unit times out
        resp_en = 1'b0;
        exp_err = 1;
        start_image();
        wait_done();
        check_counts();
        chk("wdog_out_cnt_zero", out_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
